// File: rtl/pattern_scan_scheduler.sv
// Round-robin scheduler that shares one external 1001 detector between two requesters.
// Each accepted word is shifted MSB-first into the detector; hits are counted and returned.
module pattern_scan_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    output logic             busy,
    output logic             det_reset,
    output logic             det_in,
    input  logic             det_out
);

    localparam int unsigned      KW      = $clog2(WIDTH);
    localparam logic [KW-1:0]    K_LAST  = KW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StShift,
        StDrain,
        StReport
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [KW-1:0]    k;
    logic [CNT_W-1:0] cnt;
    logic             id;
    logic             rr_last;
    logic             grant0;
    logic             grant1;

    logic pick0;
    logic pick1;
    logic accept0;
    logic accept1;

    // rr_last=1 means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (req0_valid && req1_valid) begin
            pick0 = rr_last;
            pick1 = !rr_last;
        end else begin
            pick0 = req0_valid;
            pick1 = req1_valid;
        end
    end

    assign accept0 = grant0 && req0_valid;
    assign accept1 = grant1 && req1_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StIdle;
            shreg   <= '0;
            k       <= '0;
            cnt     <= '0;
            id      <= 1'b0;
            rr_last <= 1'b1;
            grant0  <= 1'b0;
            grant1  <= 1'b0;
        end else begin
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept0 || accept1) begin
                        shreg   <= accept1 ? req1_data : req0_data;
                        id      <= accept1;
                        rr_last <= accept1;
                        cnt     <= '0;
                        state   <= StClear;
                    end else begin
                        grant0 <= pick0;
                        grant1 <= pick1;
                    end
                end
                StClear: begin
                    k     <= '0;
                    state <= StShift;
                end
                StShift: begin
                    shreg <= shreg << 1;
                    // det_out in cycle k reports the bit of cycle k-1; nothing precedes k=0.
                    if (k != '0 && det_out && cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (k == K_LAST) begin
                        state <= StDrain;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                StDrain: begin
                    if (det_out && cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    state <= StReport;
                end
                StReport: begin
                    if (res_ready) begin
                        state  <= StIdle;
                        grant0 <= pick0;
                        grant1 <= pick1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != StIdle);
    assign res_valid  = (state == StReport);
    assign res_id     = id;
    assign res_count  = cnt;
    assign res_hit    = (cnt != '0);
    assign det_reset  = (state == StIdle) || (state == StClear) || (state == StReport);
    assign det_in     = (state == StShift) && shreg[WIDTH-1];

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// Directed bench for pattern_scan_scheduler with a behavioural registered 1001 detector.
module tb_pattern_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready;
    logic       res_id;
    logic [3:0] res_count;
    logic       res_hit;
    logic       busy;
    logic       det_reset;
    logic       det_in;
    logic       det_out = 1'b0;
    logic [2:0] hist = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Detector: hit flag is registered, one cycle after the final 1 of 1001.
    always @(posedge clk) begin
        if (det_reset) begin
            hist    <= '0;
            det_out <= 1'b0;
        end else begin
            hist    <= {hist[1:0], det_in};
            det_out <= ({hist, det_in} == 4'b1001);
        end
    end

    pattern_scan_scheduler #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_count (res_count),
        .res_hit   (res_hit),
        .busy      (busy),
        .det_reset (det_reset),
        .det_in    (det_in),
        .det_out   (det_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_id"}, res_id, 0);
        check({tag, "_res_count"}, res_count, 0);
        check({tag, "_res_hit"}, res_hit, 0);
        check({tag, "_ready"}, {req1_ready, req0_ready}, 0);
        check({tag, "_det_in"}, det_in, 0);
        check({tag, "_det_reset"}, det_reset, 1);
    endtask

    // Present a word on one requester, wait for its grant, complete the accepting edge.
    task automatic submit(input logic rid, input logic [7:0] data);
        logic rdy;
        if (rid) begin
            req1_valid = 1'b1;
            req1_data  = data;
        end else begin
            req0_valid = 1'b1;
            req0_data  = data;
        end
        rdy = rid ? req1_ready : req0_ready;
        for (int i = 0; i < 20 && !rdy; i++) begin
            tick();
            rdy = rid ? req1_ready : req0_ready;
        end
        check("grant", rdy, 1);
        check("no_double_ready", req0_ready && req1_ready, 0);
        tick();
        if (rid) req1_valid = 1'b0;
        else req0_valid = 1'b0;
        check("accept_busy", busy, 1);
    endtask

    // Called right after the accepting edge; follows the scan to REPORT.
    task automatic wait_result(input logic [7:0] data, input logic exp_id, input int exp_cnt,
                               input bit consume);
        logic [7:0] cap;
        int n;
        cap = '0;
        n = 0;
        res_ready = consume;
        check("clear_det_reset", det_reset, 1);
        check("clear_det_in", det_in, 0);
        while (!res_valid && n < 30) begin
            tick();
            n++;
            if (n >= 1 && n <= 8) cap[8-n] = det_in;
            if (n == 1) check("shift_det_reset", det_reset, 0);
        end
        check("latency", n, 10);
        check("serial_bits", cap, data);
        check("res_id", res_id, exp_id);
        check("res_count", res_count, exp_cnt);
        check("res_hit", res_hit, exp_cnt != 0);
        if (consume) begin
            tick();
            check("report_done", res_valid, 0);
            check("back_idle", busy, 0);
        end
    endtask

    task automatic scan(input logic rid, input logic [7:0] data, input int exp_cnt);
        submit(rid, data);
        wait_result(data, rid, exp_cnt, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w0 [4];
        logic [7:0] w1 [4];
        int         c0 [4];
        int         c1 [4];
        logic       q_id [$];
        int         q_cnt [$];
        int         i0, i1, nacc, ndone, dbl;
        logic       acc0, acc1;

        w0 = '{8'h99, 8'h12, 8'hFF, 8'h09};
        c0 = '{2, 1, 0, 1};
        w1 = '{8'h92, 8'h00, 8'h90, 8'h48};
        c1 = '{2, 0, 1, 1};

        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_data  = '0;
        res_ready  = 1'b1;
        #1;
        check_reset_outputs("por");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        scan(1'b0, 8'b10010010, 2);
        scan(1'b1, 8'b10011001, 2);

        // Both requesters valid continuously: grants must alternate starting with 0.
        i0 = 0; i1 = 0; nacc = 0; ndone = 0; dbl = 0;
        req0_data  = w0[0];
        req1_data  = w1[0];
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = 1'b1;
        for (int cyc = 0; cyc < 300 && ndone < 8; cyc++) begin
            if (req0_ready && req1_ready) dbl++;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0 || acc1) begin
                check("rr_order", acc1, nacc % 2);
                q_id.push_back(acc1);
                q_cnt.push_back(acc1 ? c1[i1] : c0[i0]);
                nacc++;
            end
            if (res_valid && q_id.size() > 0) begin
                check("rr_res_id", res_id, q_id.pop_front());
                check("rr_res_count", res_count, q_cnt.pop_front());
                ndone++;
            end
            tick();
            if (acc0) begin
                i0++;
                if (i0 == 4) req0_valid = 1'b0;
                else req0_data = w0[i0];
            end
            if (acc1) begin
                i1++;
                if (i1 == 4) req1_valid = 1'b0;
                else req1_data = w1[i1];
            end
        end
        check("rr_results", ndone, 8);
        check("rr_double_ready", dbl, 0);
        tick();

        scan(1'b0, 8'b11111111, 0);
        scan(1'b1, 8'b00000100, 0);
        scan(1'b0, 8'b10000000, 0);

        // Back-pressure in REPORT with another request waiting.
        submit(1'b1, 8'h99);
        wait_result(8'h99, 1'b1, 2, 1'b0);
        req0_valid = 1'b1;
        req0_data  = 8'h12;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_count", res_count, 2);
            check("hold_id", res_id, 1);
            check("hold_ready", {req1_ready, req0_ready}, 0);
        end
        res_ready = 1'b1;
        tick();
        check("release_valid", res_valid, 0);
        check("release_idle", busy, 0);
        check("release_grant", req0_ready, 1);
        tick();
        check("next_accept", busy, 1);
        req0_valid = 1'b0;
        wait_result(8'h12, 1'b0, 1, 1'b1);

        // Reset in the middle of SHIFT aborts the word.
        submit(1'b0, 8'h92);
        tick();
        tick();
        tick();
        check("mid_shift_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_valid", res_valid, 0);
        scan(1'b0, 8'h90, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_scan_scheduler.md
Name: pattern_scan_scheduler

Overview:
- Shares one external 1001 sequence detector between two requesters that each submit a WIDTH-bit word to be scanned.
- Arbitrates round-robin, clears the detector, shifts the accepted word into it bit-serially MSB-first, counts detector hits, and returns a count tagged with the requester id.
- Sits between the request sources and the detector instance; it is the detector's only driver.

Parameters:
WIDTH, 8, bits per scanned word (>=4)
CNT_W, 4, width of the hit counter; the counter saturates at all-ones

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a word
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 word accepted on this edge when valid&ready
req1_valid  input  1  requester 1 has a word
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 accept strobe (same rules)
res_valid  output  1  result available
res_ready  input  1  consumer takes result when valid&ready
res_id  output  1  requester that owns the result
res_count  output  CNT_W  number of 1001 hits in the word (overlapping)
res_hit  output  1  res_count != 0
busy  output  1  state != IDLE
det_reset  output  1  active-high clear to the detector
det_in  output  1  serial bit to the detector
det_out  input  1  registered detector hit flag

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous and active-low.
- While reset_n is low: state=IDLE, busy=0, res_valid=0, res_id=0, res_count=0, res_hit=0, req*_ready=0, det_in=0, det_reset=1, rr_last=1 (so requester 0 wins first).
- Reset mid-scan aborts the word with no result.
- States: IDLE, CLEAR, SHIFT, DRAIN, REPORT. All outputs are decoded from registered state and registered datapath only.
- IDLE:
  - reqN_ready=1 only for the granted requester.
  - Grant: if only one valid, it wins. If both are valid, the one != rr_last wins.
  - On accept: capture data into shreg, set id, rr_last<=id, clear the counter, go to CLEAR.
  - ready is never high for both requesters. ready does not depend combinationally on res_ready.
- CLEAR: one cycle, det_reset=1, det_in=0, then go to SHIFT with bit index k=0.
- SHIFT:
  - Lasts exactly WIDTH cycles. det_reset=0.
  - In cycle k, det_in = word bit (WIDTH-1-k). shreg shifts left each cycle.
  - After k=WIDTH-1, go to DRAIN.
- DRAIN: one cycle, det_in=0, det_reset=0, then go to REPORT.
- Hit counting:
  - The detector responds to the bit of cycle k with det_out high in cycle k+1.
  - At each rising edge in SHIFT with k>=1, and at the DRAIN edge, the counter increments if det_out=1, saturating at 2^CNT_W-1.
  - det_out is ignored in all other states.
- REPORT:
  - res_valid=1. res_id, res_count and res_hit are stable until res_valid&res_ready.
  - On that edge, res_valid drops and state returns to IDLE.
  - A new request is accepted no earlier than the following edge.
- det_reset=1 in IDLE, CLEAR and REPORT. No match can span two words.
- Latency: res_valid rises WIDTH+2 edges after the accepting edge (10 for WIDTH=8). Throughput is one word per WIDTH+4 cycles with res_ready held high.
- Requests arriving while busy wait with valid held. The handshake does not require valid to stay high, and the block must not accept a dropped valid.
- det_in and det_reset must be glitch-free (registered or decoded from registers only).

Test Plan:
- Reset, then req0 word 8'b10010010 with res_ready=1 -> res_valid 10 edges after accept, res_id=0, res_count=2, res_hit=1.
- req1 8'b10011001 -> res_count=2; the second hit (last bit) is counted only in DRAIN.
- 8'b11111111 -> res_count=0, res_hit=0. Word 8'b00000100 followed by word 8'b10000000 -> both give 0 (no cross-word match).
- Both valid continuously, 4 words each -> grants alternate 0,1,0,1,... starting with 0; no double ready; ids match data order.
- Hold res_ready=0 for 5 cycles in REPORT -> res_* stable, no ready asserted; release -> IDLE and next accept one edge later.
- Assert reset_n low mid-SHIFT -> all outputs at reset values immediately and det_reset=1. After release, a fresh req0 scan completes correctly.
